// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared defaults, FSM state and requester-id types for the data-memory arbiter.
package mem_arb_pkg;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;
    typedef enum logic {IDLE, ACCESS} state_t;
    typedef enum logic {CORE, LDR} req_id_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin picker; a tie goes to the port not granted last.
module rr_arb2 import mem_arb_pkg::*; (
    input  logic [1:0] req,
    input  req_id_t    last,
    output req_id_t    winner,
    output logic       valid
);
    always_comb begin
        valid  = |req;
        winner = (req == 2'b10 || (req == 2'b11 && last == CORE)) ? LDR : CORE;
    end
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: arbitrates core and loader accesses onto a single-ported data memory,
// one access per cycle, with registered grants and read-data return.
module data_mem_arbiter import mem_arb_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_gnt,
    output logic              ldr_rvalid,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    state_t            state_q, state_d;
    req_id_t           last_q, cmd_id_q, winner;
    logic              valid, cmd_we_q, rd_done;
    logic [ADDR_W-1:0] cmd_addr_q;
    logic [DATA_W-1:0] cmd_wdata_q;

    rr_arb2 u_arb (
        .req    ({ldr_req, core_req}),
        .last   (last_q),
        .winner (winner),
        .valid  (valid)
    );

    // Strobes decode from state so an asynchronous reset drops mem_write at once.
    always_comb begin
        state_d   = valid ? ACCESS : IDLE;
        busy      = state_q == ACCESS;
        mem_read  = busy && !cmd_we_q;
        mem_write = busy && cmd_we_q;
        mem_addr  = busy ? cmd_addr_q : '0;
        mem_wdata = busy ? cmd_wdata_q : '0;
        rd_done   = mem_read;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= LDR;
            cmd_id_q    <= CORE;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            core_gnt    <= 1'b0;
            ldr_gnt     <= 1'b0;
            core_rvalid <= 1'b0;
            ldr_rvalid  <= 1'b0;
            core_rdata  <= '0;
            ldr_rdata   <= '0;
        end else begin
            state_q     <= state_d;
            core_gnt    <= valid && winner == CORE;
            ldr_gnt     <= valid && winner == LDR;
            core_rvalid <= rd_done && cmd_id_q == CORE;
            ldr_rvalid  <= rd_done && cmd_id_q == LDR;
            if (rd_done && cmd_id_q == CORE) core_rdata <= mem_rdata;
            if (rd_done && cmd_id_q == LDR)  ldr_rdata  <= mem_rdata;
            if (valid) begin
                last_q      <= winner;
                cmd_id_q    <= winner;
                cmd_we_q    <= winner == CORE ? core_we    : ldr_we;
                cmd_addr_q  <= winner == CORE ? core_addr  : ldr_addr;
                cmd_wdata_q <= winner == CORE ? core_wdata : ldr_wdata;
            end
        end
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed bench with a memory model and read-data scoreboard queues.
module tb_data_mem_arbiter;
    logic       clk = 0, rst_n = 0;
    logic       core_req = 0, core_we = 0, ldr_req = 0, ldr_we = 0;
    logic [3:0] core_addr = 0, ldr_addr = 0, mem_addr;
    logic [7:0] core_wdata = 0, ldr_wdata = 0, mem_wdata, mem_rdata, core_rdata, ldr_rdata;
    logic       core_gnt, core_rvalid, ldr_gnt, ldr_rvalid, mem_read, mem_write, busy;
    logic [7:0] mem [16];
    logic [7:0] model [16];
    logic [7:0] cq [$];
    logic [7:0] lq [$];
    int n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    data_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always @(negedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (core_rvalid) begin
            if (cq.size() == 0) chk("core_rvalid_unexpected", 1, 0);
            else chk("core_rdata", {24'd0, core_rdata}, {24'd0, cq.pop_front()});
        end
        if (ldr_rvalid) begin
            if (lq.size() == 0) chk("ldr_rvalid_unexpected", 1, 0);
            else chk("ldr_rdata", {24'd0, ldr_rdata}, {24'd0, lq.pop_front()});
        end
    end

    task automatic access(input bit ldr, input bit we, input logic [3:0] a, input logic [7:0] d);
        logic got = 0;
        if (ldr) begin ldr_req = 1; ldr_we = we; ldr_addr = a; ldr_wdata = d; end
        else begin core_req = 1; core_we = we; core_addr = a; core_wdata = d; end
        if (we) model[a] = d;
        else if (ldr) lq.push_back(model[a]);
        else cq.push_back(model[a]);
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk);
            @(negedge clk);
            got = ldr ? ldr_gnt : core_gnt;
        end
        chk(ldr ? "ldr_gnt" : "core_gnt", {31'd0, got}, 1);
        chk("other_gnt_low", {31'd0, ldr ? core_gnt : ldr_gnt}, 0);
        chk("mem_cmd", {18'd0, mem_write, mem_read, mem_addr, mem_wdata},
            {18'd0, we, !we, a, we ? d : 8'h00});
        if (ldr) ldr_req = 0; else core_req = 0;
    endtask

    initial begin
        foreach (mem[i]) begin mem[i] = 0; model[i] = 0; end
        repeat (3) @(negedge clk);
        chk("reset_outputs", {24'd0, core_gnt, ldr_gnt, core_rvalid, ldr_rvalid, mem_read, mem_write, busy, 1'b0}, 0);
        chk("reset_rdata", {16'd0, core_rdata, ldr_rdata}, 0);
        rst_n = 1;
        // continuous tie straight after reset: core first, then strict alternation
        core_req = 1; core_we = 1; core_addr = 4'h8; core_wdata = 8'h11;
        ldr_req  = 1; ldr_we  = 1; ldr_addr  = 4'h9; ldr_wdata  = 8'h22;
        model[8] = 8'h11; model[9] = 8'h22;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("tie_grant_%0d", i), {29'd0, core_gnt, ldr_gnt, busy},
                {29'd0, (i % 2) == 0, (i % 2) == 1, 1'b1});
        end
        core_req = 0; ldr_req = 0;
        @(negedge clk);
        chk("tie_idle", {30'd0, busy, core_gnt | ldr_gnt}, 0);
        chk("tie_mem", {16'd0, mem[8], mem[9]}, {16'd0, 8'h11, 8'h22});
        access(0, 1, 4'h3, 8'hA5);
        @(negedge clk);
        chk("write_done", {29'd0, core_gnt, core_rvalid, busy}, 0);
        chk("mem3", {24'd0, mem[3]}, 32'hA5);
        access(0, 0, 4'h3, 8'h00);
        @(negedge clk);
        chk("read_rvalid", {31'd0, core_rvalid}, 1);
        @(negedge clk);
        chk("read_rvalid_pulse", {31'd0, core_rvalid}, 0);
        chk("rdata_hold", {24'd0, core_rdata}, 32'hA5);
        access(1, 1, 4'hF, 8'h3C);
        access(0, 0, 4'hF, 8'h00);
        access(0, 1, 4'h7, 8'h55);
        access(1, 0, 4'h8, 8'h00);
        repeat (3) @(negedge clk);
        // reset mid-ACCESS of a loader write must suppress the commit
        ldr_req = 1; ldr_we = 1; ldr_addr = 4'h7; ldr_wdata = 8'hFF;
        @(posedge clk);
        #2;
        chk("rst_pre", {30'd0, ldr_gnt, mem_write}, 3);
        rst_n = 0;
        #1;
        chk("rst_async", {26'd0, core_gnt, ldr_gnt, core_rvalid, ldr_rvalid, mem_write, busy}, 0);
        chk("rst_rdata", {16'd0, core_rdata, ldr_rdata}, 0);
        ldr_req = 0;
        @(negedge clk);
        @(negedge clk);
        chk("mem7_kept", {24'd0, mem[7]}, 32'h55);
        rst_n = 1;
        core_req = 1; core_we = 0; core_addr = 4'h7;
        ldr_req  = 1; ldr_we  = 0; ldr_addr  = 4'h3;
        cq.push_back(model[7]); lq.push_back(model[3]);
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_tie", {30'd0, core_gnt, ldr_gnt}, 2);
        core_req = 0;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_second", {30'd0, core_gnt, ldr_gnt}, 1);
        ldr_req = 0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle", {25'd0, mem_read, mem_write, busy, core_gnt, ldr_gnt, core_rvalid, ldr_rvalid}, 0);
        end
        chk("queues_drained", cq.size() + lq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, data-memory address width.
REQ-002 SHALL have parameter DATA_W, default 8, data-memory word width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports core_req/core_we  input  1 each  core access request / 1 = write.
REQ-006 SHALL have ports core_addr  input  ADDR_W, and core_wdata  input  DATA_W  core command.
REQ-007 SHALL have ports core_gnt/core_rvalid  output  1 each, and core_rdata  output  DATA_W  core response.
REQ-008 SHALL have ports ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_gnt, ldr_rvalid, ldr_rdata  loader port; directions and widths as the core port.
REQ-009 SHALL have ports mem_read/mem_write  output  1 each  memory strobes.
REQ-010 SHALL have ports mem_addr  output  ADDR_W, and mem_wdata  output  DATA_W  memory command.
REQ-011 SHALL have port mem_rdata  input  DATA_W  combinational memory read data.
REQ-012 SHALL have port busy  output  1  high while in ACCESS.

Function
REQ-013 SHALL implement FSM states IDLE and ACCESS.
REQ-014 In IDLE with no request sampled: SHALL stay IDLE; mem_read = mem_write = 0; mem_addr = mem_wdata = 0.
REQ-015 At a rising edge with >=1 request: SHALL pick a winner, latch its we/addr/wdata into command registers, go to ACCESS.
REQ-016 <winner>_gnt SHALL be registered and high for exactly the ACCESS cycle of the winner's command; at most one gnt high per cycle.
REQ-017 In ACCESS: mem_read = !cmd_we, mem_write = cmd_we, mem_addr/mem_wdata = latched command; memory commits writes mid-cycle (falling edge).
REQ-018 Read: at the rising edge ending ACCESS, SHALL capture mem_rdata into the winner's rdata and pulse its rvalid for the next cycle only.
REQ-019 rdata SHALL hold its value until the next read for that port; writes SHALL never raise rvalid (gnt is the write acknowledge).
REQ-020 Requester SHALL hold req and command stable until it sees gnt; a req still high at the edge ending the gnt cycle SHALL be treated as a new request.
REQ-021 At the end of ACCESS, a pending request SHALL be arbitrated and the FSM SHALL stay in ACCESS (back-to-back, one access per cycle); otherwise it SHALL return to IDLE.
REQ-022 Arbitration SHALL be round-robin: single request wins; on a tie the port not granted last wins; last-winner register updates on every grant.
REQ-023 Under continuous tie, grants SHALL strictly alternate; no port waits more than one access.
REQ-024 Read-after-write to the same address in consecutive grants SHALL return the written value.

Reset
REQ-025 rst_n low SHALL asynchronously force IDLE, all gnt/rvalid = 0, rdata = 0, command registers = 0, last-winner = loader (core wins the first tie).
REQ-026 Reset asserted during ACCESS SHALL drop mem_write immediately, so no write commits at the following falling edge; the interrupted command is discarded, not replayed.
REQ-027 First arbitration SHALL occur at the first rising edge after rst_n deasserts.

Structure
REQ-028 Package mem_arb_pkg SHALL hold ADDR_W/DATA_W defaults, the state enum (IDLE, ACCESS) and the requester-id type (CORE, LDR).
REQ-029 The 2-way round-robin picker SHALL be a sub-module rr_arb2 (inputs req[1:0], last; outputs winner, valid); total RTL 120-400 lines.

Verification
REQ-030 Core write addr 4'h3 data 8'hA5 alone -> core_gnt one cycle later for 1 cycle, mem_write=1 addr 3, then memory[3]=8'hA5, core_rvalid stays 0.
REQ-031 Then core read addr 4'h3 -> core_gnt, then core_rvalid=1 for one cycle with core_rdata=8'hA5.
REQ-032 Both req held 6 cycles after reset -> grants core, ldr, core, ldr, core, ldr; busy continuously high; never both gnt.
REQ-033 Loader write addr 4'hF 8'h3C followed by core read 4'hF in the next grant -> core_rdata=8'h3C.
REQ-034 rst_n pulsed low during loader write ACCESS to addr 4'h7 (8'hFF) -> memory[7] unchanged, gnt/rvalid 0, state IDLE; first tie afterwards grants core.
REQ-035 No requests for 10 cycles -> mem_read=mem_write=0, busy=0, all gnt/rvalid 0.
